// File: rtl/lfsr_stream_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : lfsr_stream_checker                                             |
// | Checks a valid/ready LFSR word stream against a locally regenerated      |
// | sequence, counts mismatches and folds words into a MISR signature.       |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module lfsr_stream_checker #(
  parameter int unsigned      WIDTH        = 64,
  parameter logic [WIDTH-1:0] SEED         = 64'h5aef0c8d_d70a4497,
  parameter int unsigned      NUM_WORDS    = 90,
  parameter int unsigned      SKIP         = 9,
  parameter logic [WIDTH-1:0] EXPECTED_SUM = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mismatch_count,
  output logic [15:0]      first_err_index,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [15:0] SKIP_IDX = 16'(SKIP);
  localparam logic [15:0] NO_ERR   = 16'hFFFF;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    step = {x[WIDTH-2:0], x[WIDTH-1] ^ x[2] ^ x[0]};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] signature_q, signature_d;
  logic [15:0]      index_q, index_d;
  logic [15:0]      mismatch_q, mismatch_d;
  logic [15:0]      first_err_q, first_err_d;
  logic             pass_q, pass_d;
  logic             xfer;

  assign xfer = in_valid && (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    signature_d = signature_q;
    index_d     = index_q;
    mismatch_d  = mismatch_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          expected_d  = SEED;
          signature_d = '0;
          index_d     = '0;
          mismatch_d  = '0;
          first_err_d = NO_ERR;
          pass_d      = 1'b0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (in_data != expected_q) begin
            if (mismatch_q != 16'hFFFF) begin
              mismatch_d = mismatch_q + 16'd1;
            end
            if (first_err_q == NO_ERR) begin
              first_err_d = index_q;
            end
          end
          // Expected sequence free-runs; it never resyncs off received data.
          expected_d  = step(expected_q);
          signature_d = (index_q < SKIP_IDX) ? '0 : (in_data ^ step(signature_q));
          index_d     = index_q + 16'd1;
          if (index_q == LAST_IDX) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        pass_d  = (mismatch_q == 16'd0) && (signature_q == EXPECTED_SUM);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      expected_q  <= SEED;
      signature_q <= '0;
      index_q     <= '0;
      mismatch_q  <= '0;
      first_err_q <= NO_ERR;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      signature_q <= signature_d;
      index_q     <= index_d;
      mismatch_q  <= mismatch_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign in_ready        = (state_q == S_RUN);
  assign busy            = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign mismatch_count  = mismatch_q;
  assign first_err_index = first_err_q;
  assign signature       = signature_q;

endmodule
`default_nettype wire
